// File: rtl/ab_debounce.sv
// Two-channel switch debouncer: per channel a 2-flop synchronizer, a stability-counter FSM and a rise pulse.
// Define AB_DEBOUNCE_BYPASS_EN to drop the counters so each level follows its synchronizer directly.

module ab_debounce_ch #(
  parameter int CNT_W      = 16,
  parameter int STABLE_CNT = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic level,
  output logic rise
);

  logic s1;
  logic s2;

  // Only s2 is allowed to reach any logic below; s1 may be metastable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sw;
      s2 <= s1;
    end
  end

`ifdef AB_DEBOUNCE_BYPASS_EN

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      level <= s2;
      rise  <= s2 & ~level;
    end
  end

`else

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             level_next;
  logic             rise_next;
  logic             differ;
  logic             cnt_done;

  assign differ   = (s2 != level);
  assign cnt_done = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_STABLE;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      level <= level_next;
      rise  <= rise_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_STABLE: begin
        if (differ) state_next = ST_COUNTING;
      end
      ST_COUNTING: begin
        if (!differ || cnt_done) state_next = ST_STABLE;
      end
      default: state_next = ST_STABLE;
    endcase
  end

  // A glitch back to the current level abandons the count without touching the output.
  always_comb begin
    cnt_next   = '0;
    level_next = level;
    rise_next  = 1'b0;
    case (state)
      ST_STABLE: begin
        if (differ) cnt_next = CNT_ONE;
      end
      ST_COUNTING: begin
        if (!differ) begin
          cnt_next = '0;
        end else if (cnt_done) begin
          level_next = s2;
          rise_next  = s2;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: cnt_next = '0;
    endcase
  end

`endif

endmodule

module ab_debounce #(
  parameter int CNT_W      = 16,
  parameter int STABLE_CNT = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_a,
  input  logic sw_b,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic b_rise
);

  ab_debounce_ch #(.CNT_W(CNT_W), .STABLE_CNT(STABLE_CNT)) u_ch_a (
    .clk   (clk),
    .rst   (rst),
    .sw    (sw_a),
    .level (a),
    .rise  (a_rise)
  );

  ab_debounce_ch #(.CNT_W(CNT_W), .STABLE_CNT(STABLE_CNT)) u_ch_b (
    .clk   (clk),
    .rst   (rst),
    .sw    (sw_b),
    .level (b),
    .rise  (b_rise)
  );

endmodule

// File: tb/tb_ab_debounce.sv
// Directed bench for ab_debounce with STABLE_CNT=4; expected latency switches with AB_DEBOUNCE_BYPASS_EN.

module tb_ab_debounce;

  localparam int CNT_W      = 4;
  localparam int STABLE_CNT = 4;
`ifdef AB_DEBOUNCE_BYPASS_EN
  localparam int LAT = 3;
`else
  localparam int LAT = STABLE_CNT + 2;
`endif

  logic clk;
  logic rst;
  logic sw_a;
  logic sw_b;
  logic a;
  logic b;
  logic a_rise;
  logic b_rise;

  int n_tests;
  int n_fail;

  ab_debounce #(.CNT_W(CNT_W), .STABLE_CNT(STABLE_CNT)) dut (
    .clk    (clk),
    .rst    (rst),
    .sw_a   (sw_a),
    .sw_b   (sw_b),
    .a      (a),
    .b      (b),
    .a_rise (a_rise),
    .b_rise (b_rise)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    sw_a = 1'b1;
    sw_b = 1'b1;
    #2;
    n_tests++;
    if ({a, b, a_rise, b_rise} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_async: got %b want 0000", {a, b, a_rise, b_rise});
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_tests++;
      if ({a, b, a_rise, b_rise} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_hold k=%0d: got %b want 0000", k, {a, b, a_rise, b_rise});
      end
    end
    sw_a = 1'b0;
    sw_b = 1'b0;
    tick();
    rst = 1'b0;
    settle(3);
    n_tests++;
    if ({a, b, a_rise, b_rise} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_release: got %b want 0000", {a, b, a_rise, b_rise});
    end
  endtask

  task automatic test_rise_a();
    sw_a = 1'b1;
    for (int k = 1; k <= LAT + 3; k++) begin
      tick();
      n_tests++;
      if (a !== (k >= LAT) || a_rise !== (k == LAT) || b !== 1'b0 || b_rise !== 1'b0) begin
        n_fail++;
        $display("FAIL rise_a k=%0d: got a=%b ar=%b b=%b br=%b want a=%b ar=%b b=0 br=0",
                 k, a, a_rise, b, b_rise, k >= LAT, k == LAT);
      end
    end
  endtask

  task automatic test_fall_a();
    sw_a = 1'b0;
    for (int k = 1; k <= LAT + 3; k++) begin
      tick();
      n_tests++;
      if (a !== (k < LAT) || a_rise !== 1'b0) begin
        n_fail++;
        $display("FAIL fall_a k=%0d: got a=%b ar=%b want a=%b ar=0", k, a, a_rise, k < LAT);
      end
    end
  endtask

  task automatic test_glitch_a();
    logic exp_a;
    logic exp_r;
    sw_a = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 2) sw_a = 1'b0;
`ifdef AB_DEBOUNCE_BYPASS_EN
      exp_a = (k == 3 || k == 4);
      exp_r = (k == 3);
`else
      exp_a = 1'b0;
      exp_r = 1'b0;
`endif
      n_tests++;
      if (a !== exp_a || a_rise !== exp_r) begin
        n_fail++;
        $display("FAIL glitch_a k=%0d: got a=%b ar=%b want a=%b ar=%b", k, a, a_rise, exp_a, exp_r);
      end
    end
  endtask

  task automatic test_both_rise();
    sw_a = 1'b1;
    sw_b = 1'b1;
    for (int k = 1; k <= LAT + 2; k++) begin
      tick();
      n_tests++;
      if (a !== (k >= LAT) || b !== (k >= LAT) || a_rise !== (k == LAT) || b_rise !== (k == LAT)) begin
        n_fail++;
        $display("FAIL both_rise k=%0d: got a=%b b=%b ar=%b br=%b want a=b=%b ar=br=%b",
                 k, a, b, a_rise, b_rise, k >= LAT, k == LAT);
      end
    end
    sw_a = 1'b0;
    sw_b = 1'b0;
    settle(LAT + 2);
    n_tests++;
    if ({a, b, a_rise, b_rise} !== 4'b0000) begin
      n_fail++;
      $display("FAIL both_fall: got %b want 0000", {a, b, a_rise, b_rise});
    end
  endtask

  task automatic test_reset_mid_count();
    sw_b = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_tests++;
      if (b !== (k >= LAT)) begin
        n_fail++;
        $display("FAIL mid_pre k=%0d: got b=%b want %b", k, b, k >= LAT);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_tests++;
    if (b !== 1'b0 || b_rise !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_async: got b=%b br=%b want b=0 br=0", b, b_rise);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 1; k <= LAT + 2; k++) begin
      tick();
      n_tests++;
      if (b !== (k >= LAT) || b_rise !== (k == LAT) || a !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_post k=%0d: got b=%b br=%b a=%b want b=%b br=%b a=0",
                 k, b, b_rise, a, k >= LAT, k == LAT);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    sw_a    = 1'b0;
    sw_b    = 1'b0;
    test_reset();
    test_rise_a();
    test_fall_a();
    test_glitch_a();
    test_both_rise();
    test_reset_mid_count();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
